// File: rtl/lvg_seq_if.sv
// Stream interface between a word source/sink and the lvg_seq command sequencer.
// The input stream carries headers and matrix words; the output stream carries
// the 16 result words in row-major order.
interface lvg_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    // Producer of input words and consumer of result words.
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    // The sequencer side.
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/lvg_seq.sv
// lvg_seq: upstream command sequencer for the lvg 4x4 FP32 matrix unit.
// Assembles L, R and A operands from a header/data word stream, issues load and
// exec opcodes, waits the fixed compute latency, captures B and drains it as
// 16 row-major words. Element ij lives at bits [32*(4*(i-1)+(j-1)) +: 32].
module lvg_seq #(
    parameter int unsigned LAT = 16
) (
    input  logic           clk,
    input  logic           rst,
    lvg_seq_if.slave       bus,
    output logic [7:0]     instr,
    output logic [511:0]   l_flat,
    output logic [511:0]   r_flat,
    output logic [511:0]   a_flat,
    input  logic [511:0]   b_flat,
    output logic           busy,
    output logic           err
);
    localparam logic [7:0] LAT_M1 = 8'(LAT - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        ISSUE_LD = 3'd2,
        ISSUE_EX = 3'd3,
        WAIT     = 3'd4,
        DRAIN    = 3'd5
    } state_t;

    state_t         state_r;
    state_t         next_state_s;
    logic           kind_r;      // 0: LOAD_L, 1: LOAD_RA
    logic [7:0]     op_r;
    logic [4:0]     cnt_r;
    logic [7:0]     lat_r;
    logic [3:0]     idx_r;
    logic [511:0]   l_r;
    logic [511:0]   r_r;
    logic [511:0]   a_r;
    logic [511:0]   res_r;
    logic           err_r;
    logic           err_s;
    logic           last_s;
    logic           in_ready_s;
    logic [7:0]     instr_s;
    logic           out_valid_s;
    logic [31:0]    out_data_s;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic and Moore output decode from the registered state.
    always_comb begin
        next_state_s = state_r;
        in_ready_s   = 1'b0;
        instr_s      = 8'd0;
        out_valid_s  = 1'b0;
        out_data_s   = 32'd0;
        err_s        = 1'b0;
        last_s       = kind_r ? (cnt_r == 5'd31) : (cnt_r == 5'd15);
        case (state_r)
            IDLE: begin
                in_ready_s = 1'b1;
                if (bus.in_valid) begin
                    case (bus.in_data[31:30])
                        2'b00, 2'b01: next_state_s = LOAD;
                        2'b10: begin
                            // Opcodes 0..2 collide with load/no-op codes and are refused.
                            if (bus.in_data[7:0] <= 8'd2) begin
                                err_s = 1'b1;
                            end else begin
                                next_state_s = ISSUE_EX;
                            end
                        end
                        default: err_s = 1'b1;
                    endcase
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOAD: begin
                in_ready_s = 1'b1;
                if (bus.in_valid && last_s) begin
                    next_state_s = ISSUE_LD;
                end else begin
                    next_state_s = LOAD;
                end
            end
            ISSUE_LD: begin
                instr_s      = kind_r ? 8'd2 : 8'd1;
                next_state_s = IDLE;
            end
            ISSUE_EX: begin
                instr_s      = op_r;
                next_state_s = WAIT;
            end
            WAIT: begin
                if (lat_r == 8'd0) begin
                    next_state_s = DRAIN;
                end else begin
                    next_state_s = WAIT;
                end
            end
            DRAIN: begin
                out_valid_s = 1'b1;
                out_data_s  = res_r[{idx_r, 5'd0} +: 32];
                if (bus.out_ready && (idx_r == 4'd15)) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DRAIN;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Datapath: header latching, matrix writes, latency count, capture, drain index.
    always_ff @(posedge clk) begin
        if (rst) begin
            kind_r <= 1'b0;
            op_r   <= 8'd0;
            cnt_r  <= 5'd0;
            lat_r  <= 8'd0;
            idx_r  <= 4'd0;
            l_r    <= 512'd0;
            r_r    <= 512'd0;
            a_r    <= 512'd0;
            res_r  <= 512'd0;
            err_r  <= 1'b0;
        end else begin
            err_r <= err_s;
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        kind_r <= bus.in_data[30];
                        op_r   <= bus.in_data[7:0];
                        cnt_r  <= 5'd0;
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        if (!kind_r) begin
                            l_r[{cnt_r[3:0], 5'd0} +: 32] <= bus.in_data;
                        end else if (!cnt_r[4]) begin
                            r_r[{cnt_r[3:0], 5'd0} +: 32] <= bus.in_data;
                        end else begin
                            a_r[{cnt_r[3:0], 5'd0} +: 32] <= bus.in_data;
                        end
                        cnt_r <= cnt_r + 5'd1;
                    end
                end
                ISSUE_EX: begin
                    lat_r <= LAT_M1;
                    idx_r <= 4'd0;
                end
                WAIT: begin
                    if (lat_r == 8'd0) begin
                        res_r <= b_flat;
                    end else begin
                        lat_r <= lat_r - 8'd1;
                    end
                end
                DRAIN: begin
                    if (bus.out_ready) begin
                        idx_r <= idx_r + 4'd1;
                    end
                end
                default: begin
                    idx_r <= idx_r;
                end
            endcase
        end
    end

    // Output wiring; in_ready is forced low whenever reset is asserted.
    always_comb begin
        bus.in_ready  = in_ready_s && !rst;
        bus.out_valid = out_valid_s;
        bus.out_data  = out_data_s;
        instr         = instr_s;
        l_flat        = l_r;
        r_flat        = r_r;
        a_flat        = a_r;
        busy          = (state_r != IDLE);
        err           = err_r;
    end
endmodule

// File: tb/tb_lvg_seq.sv
// Directed self-checking bench for lvg_seq with a cycle-count B stub.
module tb_lvg_seq;
    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   instr;
    logic [511:0] l_flat, r_flat, a_flat, b_flat;
    logic         busy, err;
    int           cyc = 0;
    int           total = 0;
    int           bad = 0;
    logic [511:0] exp_l, exp_r, exp_a;

    lvg_seq_if bus_if ();

    lvg_seq #(.LAT(16)) dut (
        .clk(clk), .rst(rst), .bus(bus_if), .instr(instr),
        .l_flat(l_flat), .r_flat(r_flat), .a_flat(a_flat), .b_flat(b_flat),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Cycle counter feeding the B stub.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] bpat(input int c, input int e);
        return 32'hA500_0000 ^ 32'((c << 8) + e);
    endfunction

    // B stub: every element encodes the current cycle count and its index.
    always_comb begin
        b_flat = 512'd0;
        for (int e = 0; e < 16; e++) b_flat[32*e +: 32] = bpat(cyc, e);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one word (after optional idle cycles) and hold it until accepted.
    task automatic drive_word(input logic [31:0] w, input int stalls);
        int guard;
        bus_if.in_valid = 1'b0;
        for (int s = 0; s < stalls; s++) step();
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = w;
        guard = 0;
        while (!bus_if.in_ready && guard < 50) begin
            step();
            guard++;
        end
        if (guard >= 50) begin
            total++; bad++;
            $display("FAIL drive_word timeout: in_ready=%0b required 1", bus_if.in_ready);
        end
        step();
        bus_if.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.in_valid = 1'b0; bus_if.in_data = 32'd0; bus_if.out_ready = 1'b1;
        step();
        total++;
        if (bus_if.in_ready !== 1'b0) begin
            bad++; $display("FAIL reset_in_ready: got %0b want 0", bus_if.in_ready);
        end
        step();
        rst = 1'b0;
        #1;
        total++;
        if ({l_flat, r_flat, a_flat} !== 1536'd0 || instr !== 8'd0 || bus_if.out_valid !== 1'b0 ||
            bus_if.out_data !== 32'd0 || err !== 1'b0 || busy !== 1'b0 || bus_if.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: instr=%h ov=%b od=%h err=%b busy=%b rdy=%b want all 0, rdy 1",
                     instr, bus_if.out_valid, bus_if.out_data, err, busy, bus_if.in_ready);
        end
    endtask

    task automatic test_load_l();
        exp_l = 512'd0;
        exp_l[31:0]  = 32'h3f800000;
        exp_l[63:32] = 32'h3f800000;
        drive_word(32'h0000_0000, 0);
        for (int i = 0; i < 15; i++) begin
            drive_word(exp_l[32*i +: 32], 0);
            total++;
            if (instr !== 8'd0) begin
                bad++; $display("FAIL load_l_instr_early: got %h want 00 at word %0d", instr, i);
            end
        end
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = exp_l[32*15 +: 32];
        total++;
        if (bus_if.in_ready !== 1'b1 || instr !== 8'd0) begin
            bad++; $display("FAIL load_l_last_word: rdy=%b instr=%h want 1/00", bus_if.in_ready, instr);
        end
        step();
        bus_if.in_valid = 1'b0;
        total++;
        if (instr !== 8'd1 || busy !== 1'b1 || bus_if.in_ready !== 1'b0) begin
            bad++; $display("FAIL load_l_issue: instr=%h busy=%b rdy=%b want 01/1/0", instr, busy, bus_if.in_ready);
        end
        step();
        total++;
        if (instr !== 8'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL load_l_after: instr=%h busy=%b want 00/0", instr, busy);
        end
        total++;
        if (l_flat !== exp_l || r_flat !== 512'd0 || a_flat !== 512'd0) begin
            bad++; $display("FAIL load_l_data: l[63:0]=%h want %h", l_flat[63:0], exp_l[63:0]);
        end
    endtask

    task automatic test_load_ra();
        logic [31:0] rv [8];
        logic [31:0] av [4];
        int seen;
        rv = '{32'h3fce5aee, 32'h3e8a1b2c, 32'hbf123456, 32'h3f000001,
               32'hc0490fdb, 32'h3dcccccd, 32'hbf800000, 32'h3efac258};
        av = '{32'hbfd2cfe4, 32'h3f67aa55, 32'hbe5ad35d, 32'hbec98ed1};
        exp_r = 512'd0;
        exp_a = 512'd0;
        for (int i = 0; i < 8; i++) exp_r[32*i +: 32] = rv[i];
        for (int i = 0; i < 4; i++) exp_a[32*i +: 32] = av[i];
        drive_word(32'h4000_0000, 0);
        for (int i = 0; i < 31; i++) begin
            drive_word((i < 16) ? exp_r[32*i +: 32] : exp_a[32*(i-16) +: 32], int'($urandom_range(0, 2)));
        end
        seen = 0;
        drive_word(exp_a[32*15 +: 32], 1);
        for (int k = 0; k < 3; k++) begin
            if (instr === 8'd2) seen++;
            step();
        end
        total++;
        if (seen != 1) begin
            bad++; $display("FAIL load_ra_instr: cycles with instr=02 got %0d want 1", seen);
        end
        total++;
        if (r_flat !== exp_r) begin
            bad++; $display("FAIL load_ra_r: got %h want %h", r_flat[255:0], exp_r[255:0]);
        end
        total++;
        if (a_flat !== exp_a) begin
            bad++; $display("FAIL load_ra_a: got %h want %h", a_flat[127:0], exp_a[127:0]);
        end
        total++;
        if (l_flat !== exp_l) begin
            bad++; $display("FAIL load_ra_l_held: got %h want %h", l_flat[63:0], exp_l[63:0]);
        end
    endtask

    task automatic test_exec();
        int ct;
        logic [31:0] expw [16];
        bus_if.out_ready = 1'b1;
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = 32'h8000_0007;
        ct = cyc;
        total++;
        if (instr !== 8'd0) begin
            bad++; $display("FAIL exec_instr_T: got %h want 00", instr);
        end
        step();
        bus_if.in_valid = 1'b0;
        for (int e = 0; e < 16; e++) expw[e] = bpat(ct + 17, e);
        total++;
        if (instr !== 8'h07) begin
            bad++; $display("FAIL exec_instr_T1: got %h want 07", instr);
        end
        for (int k = 2; k <= 17; k++) begin
            step();
            total++;
            if (bus_if.out_valid !== 1'b0 || instr !== 8'd0 || bus_if.in_ready !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL exec_wait: cycle T+%0d ov=%b instr=%h rdy=%b busy=%b want 0/00/0/1",
                         k, bus_if.out_valid, instr, bus_if.in_ready, busy);
            end
        end
        step();
        for (int e = 0; e < 16; e++) begin
            total++;
            if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== expw[e]) begin
                bad++;
                $display("FAIL exec_out[%0d]: ov=%b data=%h want 1/%h", e, bus_if.out_valid, bus_if.out_data, expw[e]);
            end
            step();
        end
        total++;
        if (bus_if.out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL exec_done: ov=%b busy=%b want 0/0", bus_if.out_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        int ct, e, hold, guard;
        logic alt, rdy;
        logic [31:0] expw [16];
        bus_if.out_ready = 1'b0;
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = 32'h8000_0009;
        ct = cyc;
        step();
        bus_if.in_valid = 1'b0;
        for (int i = 0; i < 16; i++) expw[i] = bpat(ct + 17, i);
        guard = 0;
        while (bus_if.out_valid !== 1'b1 && guard < 100) begin
            step();
            guard++;
        end
        total++;
        if (guard >= 100) begin
            bad++; $display("FAIL bp_wait_timeout: out_valid=%b want 1", bus_if.out_valid);
        end
        e = 0; hold = 0; alt = 1'b1; guard = 0;
        while (e < 16 && guard < 200) begin
            if (e == 4 && hold < 3) begin
                rdy = 1'b0; hold++;
            end else if (e >= 4) begin
                rdy = alt; alt = ~alt;
            end else begin
                rdy = 1'b1;
            end
            bus_if.out_ready = rdy;
            total++;
            if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== expw[e]) begin
                bad++;
                $display("FAIL bp_out[%0d]: ov=%b data=%h want 1/%h", e, bus_if.out_valid, bus_if.out_data, expw[e]);
            end
            step();
            if (rdy) e++;
            guard++;
        end
        bus_if.out_ready = 1'b1;
        total++;
        if (bus_if.out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL bp_done: ov=%b busy=%b want 0/0", bus_if.out_valid, busy);
        end
    endtask

    task automatic test_err();
        logic [31:0] hdrs [3];
        hdrs = '{32'h8000_0001, 32'hC000_0000, 32'h8000_0002};
        for (int h = 0; h < 3; h++) begin
            bus_if.in_valid = 1'b1;
            bus_if.in_data  = hdrs[h];
            total++;
            if (bus_if.in_ready !== 1'b1 || err !== 1'b0) begin
                bad++; $display("FAIL err_pre[%0d]: rdy=%b err=%b want 1/0", h, bus_if.in_ready, err);
            end
            step();
            bus_if.in_valid = 1'b0;
            total++;
            if (err !== 1'b1 || busy !== 1'b0 || instr !== 8'd0) begin
                bad++; $display("FAIL err_pulse[%0d]: err=%b busy=%b instr=%h want 1/0/00", h, err, busy, instr);
            end
            step();
            total++;
            if (err !== 1'b0 || busy !== 1'b0 || instr !== 8'd0) begin
                bad++; $display("FAIL err_after[%0d]: err=%b busy=%b instr=%h want 0/0/00", h, err, busy, instr);
            end
        end
    endtask

    task automatic test_rst_mid();
        logic [511:0] fresh;
        int ov_seen;
        drive_word(32'h0000_0000, 0);
        for (int i = 0; i < 6; i++) drive_word(32'h5555_0000 + 32'(i), 0);
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = 32'h5555_0006;
        rst = 1'b1;
        #1;
        total++;
        if (bus_if.in_ready !== 1'b0) begin
            bad++; $display("FAIL rst_load_rdy: got %b want 0", bus_if.in_ready);
        end
        step();
        rst = 1'b0;
        bus_if.in_valid = 1'b0;
        #1;
        total++;
        if ({l_flat, r_flat, a_flat} !== 1536'd0 || instr !== 8'd0 || bus_if.out_valid !== 1'b0 ||
            busy !== 1'b0 || bus_if.in_ready !== 1'b1) begin
            bad++; $display("FAIL rst_load_state: l0=%h r0=%h instr=%h busy=%b rdy=%b want 0/0/00/0/1",
                            l_flat[31:0], r_flat[31:0], instr, busy, bus_if.in_ready);
        end
        drive_word(32'h8000_0005, 0);
        for (int k = 0; k < 5; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || instr !== 8'd0 || bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b1) begin
            bad++; $display("FAIL rst_wait_state: busy=%b instr=%h ov=%b rdy=%b want 0/00/0/1",
                            busy, instr, bus_if.out_valid, bus_if.in_ready);
        end
        ov_seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus_if.out_valid === 1'b1) ov_seen++;
            step();
        end
        total++;
        if (ov_seen != 0) begin
            bad++; $display("FAIL rst_wait_no_out: out_valid cycles got %0d want 0", ov_seen);
        end
        fresh = 512'd0;
        for (int i = 0; i < 16; i++) fresh[32*i +: 32] = 32'h1000_0000 + 32'(i);
        drive_word(32'h0000_0000, 0);
        for (int i = 0; i < 16; i++) drive_word(fresh[32*i +: 32], 0);
        total++;
        if (instr !== 8'd1) begin
            bad++; $display("FAIL fresh_load_instr: got %h want 01", instr);
        end
        step();
        total++;
        if (l_flat !== fresh || busy !== 1'b0 || r_flat !== 512'd0) begin
            bad++; $display("FAIL fresh_load_data: l[63:0]=%h busy=%b want %h/0", l_flat[63:0], busy, fresh[63:0]);
        end
    endtask

    initial begin
        test_reset();
        test_load_l();
        test_load_ra();
        test_exec();
        test_back_to_back();
        test_err();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
